// File: rtl/ula_pkg.sv
// ula_pkg: shared ALU op codes and multiplier FSM state encoding
package ula_pkg;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ula_mult_ctrl.sv
// ula_mult_ctrl: 32-iteration shift-add multiplier that borrows an external 32-bit ALU
module ula_mult_ctrl
    import ula_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] ula_a,
    output logic [31:0] ula_b,
    output logic [2:0]  ula_ctrl,
    input  logic [31:0] ula_y,
    input  logic        ula_overflow
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic        sgn_q, sgn_d, busy_q, busy_d, done_q, done_d;
    logic        in_calc, ext;

    always_comb begin
        in_calc  = state_q == CALC;
        ula_a    = in_calc ? hi_q : '0;
        ula_b    = (in_calc && lo_q[0]) ? mcand_q : '0;
        // Signed multiplier bit 31 carries weight -2^31, so the last step subtracts
        ula_ctrl = (in_calc && sgn_q && cnt_q == 5'd31) ? ULA_SUB : ULA_ADD;
        // Signed: true sign of the sum; unsigned: carry-out recovered from sign bits
        ext      = sgn_q ? (ula_y[31] ^ ula_overflow)
                         : ((ula_a[31] & ula_b[31]) | ((ula_a[31] | ula_b[31]) & ~ula_y[31]));
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        sgn_d    = sgn_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CALC;
                hi_d    = '0;
                lo_d    = b_in;
                mcand_d = a_in;
                sgn_d   = is_signed;
                cnt_d   = '0;
            end
            CALC: begin
                hi_d    = {ext, ula_y[31:1]};
                lo_d    = {ula_y[0], lo_q[31:1]};
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? DONE : CALC;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ula_mult_ctrl.sv
// tb_ula_mult_ctrl: directed product table plus busy-start and mid-operation reset sequences
module tb_ula_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, is_signed;
    logic [31:0] a_in, b_in, hi, lo, ula_a, ula_b, ula_y;
    logic [2:0]  ula_ctrl;
    logic        busy, done, ula_overflow;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ula_mult_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .ula_a(ula_a), .ula_b(ula_b), .ula_ctrl(ula_ctrl),
        .ula_y(ula_y), .ula_overflow(ula_overflow)
    );

    // Reference ALU: add/subtract with two's-complement overflow
    always_comb begin
        ula_y        = (ula_ctrl == 3'b110) ? ula_a - ula_b : ula_a + ula_b;
        ula_overflow = (ula_ctrl == 3'b110)
                     ? (ula_a[31] != ula_b[31]) && (ula_y[31] != ula_a[31])
                     : (ula_a[31] == ula_b[31]) && (ula_y[31] != ula_a[31]);
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one multiply; optional start pulses at cycles 5 and 20 must be ignored
    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic pulse, output int lat, output int nbusy_low);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; a_in = a; b_in = b;
        @(posedge clk);
        lat = 0;
        nbusy_low = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            start     = pulse && (lat == 5 || lat == 20);
            a_in      = ~a;
            b_in      = b ^ 32'h5A5A_A5A5;
            is_signed = ~sgn;
            if (!busy) nbusy_low++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, nbl, ndone;
        vecs[0] = '{1'b0, 32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[4] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000};
        vecs[8] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2};
        vecs[9] = '{1'b0, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("idle_ula", {ula_a, ula_b}, 64'd0);
        chk("idle_ctrl", 64'(ula_ctrl), 64'd2);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, lat, nbl);
            chk($sformatf("lat[%0d]", i), 64'(lat), 64'd33);
            chk($sformatf("busy[%0d]", i), 64'(nbl), 64'd0);
            chk($sformatf("prod[%0d]", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            @(negedge clk);
            chk($sformatf("post[%0d]", i), {62'd0, busy, done}, 64'd0);
            repeat (3) @(negedge clk);
            chk($sformatf("hold[%0d]", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
        end

        // Starts during CALC must not restart or queue an operation
        run(1'b0, 32'd3, 32'd5, 1'b1, lat, nbl);
        chk("busy_start_lat", 64'(lat), 64'd33);
        chk("busy_start_prod", {hi, lo}, 64'h0000_0000_0000_000F);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("busy_start_extra_done", 64'(ndone), 64'd0);

        // Reset sampled at edge 10 abandons the operation; restart at edge 12
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; a_in = 32'hFFFF_FFFD; b_in = 32'd5;
        @(posedge clk);
        ndone = 0;
        lat = 0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
            reset = (n == 10);
        end
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a_in = 32'd3; b_in = 32'd5;
        for (int n = 13; n <= 45; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && n < 45) ndone++;
            if (n == 45) lat = done ? 45 : 0;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        chk("rst_restart_done45", 64'(lat), 64'd45);
        chk("rst_restart_prod", {hi, lo}, 64'h0000_0000_0000_000F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
